// File: rtl/gray_handshake_counter.sv
// Four-phase req/ack handshake counter exposing the count in binary and reflected Gray code.
// Width, ack latency, count direction and wrap/saturate behaviour are configurable.
module gray_handshake_counter #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DELAY = 1,
  parameter int unsigned WRAP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  output logic             ack,
  output logic [WIDTH-1:0] count_gray,
  output logic [WIDTH-1:0] count_bin,
  output logic             ovf
);

  localparam int unsigned   TW        = (DELAY < 2) ? 1 : $clog2(DELAY + 1);
  localparam logic [TW-1:0] TimerOne  = TW'(1);
  localparam logic [TW-1:0] TimerLast = TW'(DELAY);
  localparam logic [WIDTH-1:0] BinOne = WIDTH'(1);

  typedef enum logic [1:0] {
    StIdle,
    StRiseWait,
    StAckHi,
    StFallWait
  } state_e;

  state_e          state_q;
  logic [TW-1:0]   timer_q;
  logic            dir_q;
  logic            at_end;
  logic [WIDTH-1:0] bin_step;
  logic [WIDTH-1:0] bin_nxt;
  logic [WIDTH-1:0] gray_nxt;

  // at_end flags the step that would leave the code space in the latched direction.
  always_comb begin
    at_end   = dir_q ? (count_bin == '0) : (count_bin == '1);
    bin_step = dir_q ? (count_bin - BinOne) : (count_bin + BinOne);
    bin_nxt  = (at_end && (WRAP == 0)) ? count_bin : bin_step;
    gray_nxt = bin_nxt ^ (bin_nxt >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      dir_q      <= 1'b0;
      ack        <= 1'b0;
      count_bin  <= '0;
      count_gray <= '0;
      ovf        <= 1'b0;
    end else begin
      ovf <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            dir_q   <= dir;
            timer_q <= TimerOne;
            state_q <= StRiseWait;
          end
        end
        // start is deliberately ignored while waiting; a phase always runs to completion.
        StRiseWait: begin
          if (timer_q == TimerLast) begin
            ack        <= 1'b1;
            count_bin  <= bin_nxt;
            count_gray <= gray_nxt;
            ovf        <= at_end;
            state_q    <= StAckHi;
          end else begin
            timer_q <= timer_q + TimerOne;
          end
        end
        StAckHi: begin
          if (!start) begin
            timer_q <= TimerOne;
            state_q <= StFallWait;
          end
        end
        StFallWait: begin
          if (timer_q == TimerLast) begin
            ack     <= 1'b0;
            state_q <= StIdle;
          end else begin
            timer_q <= timer_q + TimerOne;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/gray_handshake_counter.md
Name: gray_handshake_counter

Overview:
- Parametrised successor to the team's 2-bit handshake Gray counter.
- Counts completed four-phase req/ack handshakes on start/ack and exposes the count in reflected Gray code and in binary.
- Adds configurable width, configurable ack latency, up/down direction and wrap-or-saturate mode, and is fully clocked.
- Sits between an asynchronous-style controller and the datapath, typically as an event/sequence index generator.

Parameters:
- WIDTH, 2, counter width in bits; must be at least 2.
- DELAY, 1, number of clock edges from the edge that samples a start transition to the edge that changes ack; must be at least 1.
- WRAP, 1, 1 = modulo 2^WIDTH wrap-around; 0 = saturate at the end values.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  four-phase request; synchronous to clk.
- dir  input  1  count direction (0 = up, 1 = down); latched when a handshake begins.
- ack  output  1  four-phase acknowledge; registered.
- count_gray  output  WIDTH  registered Gray-code count.
- count_bin  output  WIDTH  registered binary count; count_gray == count_bin ^ (count_bin >> 1) at all times.
- ovf  output  1  one-cycle pulse on the edge where the count would pass an end value.

Behaviour:
- Reset is synchronous and active-high on clk. While rst=1 at an edge: ack=0, count_gray=0, count_bin=0, ovf=0, state=IDLE, timer=0, latched dir=0. rst overrides every other input, including mid-handshake.
- FSM states: IDLE, RISE_WAIT, ACK_HI, FALL_WAIT.
- IDLE: an edge sampling start=1 latches dir, loads timer=1 and moves to RISE_WAIT. start=0 keeps the FSM in IDLE.
- RISE_WAIT: the timer increments each edge. On the edge where timer==DELAY, the following happen together: ack<=1, the count updates, ovf may pulse, and the state moves to ACK_HI. ack therefore rises exactly DELAY edges after the sampling edge; with DELAY=1 that is the next edge.
- ACK_HI: an edge sampling start=0 loads timer=1 and moves to FALL_WAIT. start=1 holds ACK_HI.
- FALL_WAIT: on the edge where timer==DELAY, ack<=0 and the state moves to IDLE. The count does not change on the falling phase.
- start toggled during RISE_WAIT or FALL_WAIT is a protocol violation. The FSM ignores it and completes the current phase unchanged. No phase is ever skipped.
- Exactly one count update occurs per completed rising phase.
- Update arithmetic is done in binary, modulo 2^WIDTH; count_gray is derived from the next binary value and registered on the same edge.
- Up from binary 2^WIDTH-1, or down from 0:
  - WRAP=1: wraps to 0, or to 2^WIDTH-1 when counting down.
  - WRAP=0: holds the value.
  - Both modes: ovf=1 for that one cycle.
- ovf is 0 on every other cycle.
- dir changes after latching have no effect until the next IDLE->RISE_WAIT transition.
- Successive count_gray values always differ in exactly one bit, except when WRAP=0 holds at an end value (zero bits change).
- If start=1 on the first edge after rst deasserts, a new handshake begins normally from IDLE.
- Handshake throughput: at most one count per 2*DELAY+2 edges.

Test Plan:
- Default params (WIDTH=2, DELAY=1, WRAP=1), dir=0, four full handshakes -> count_gray 00->01->11->10->00; ovf=1 only on the fourth ack rise; ack rises 1 edge after start is sampled high and falls 1 edge after start is sampled low.
- WIDTH=3, DELAY=3, dir=1 from reset, two handshakes -> count_bin 111 then 110, count_gray 100 then 101; ovf pulses on the first ack rise; each ack edge lands exactly 3 edges after the sampling edge.
- WIDTH=3, WRAP=0, dir=0, 9 handshakes -> count_bin saturates at 7 (count_gray 100) from the 7th handshake on; ovf pulses on the 8th and 9th ack rises; ack still completes every handshake.
- DELAY=4, start dropped 2 edges into RISE_WAIT -> ack still rises at edge 4 with one count update, then FSM enters FALL_WAIT on the next edge and ack falls 4 edges later.
- rst pulsed while ACK_HI with count_bin=2 -> next edge: ack=0, count_bin=0, count_gray=0, ovf=0; start held high through reset release starts a fresh handshake whose ack rises DELAY edges after the first post-reset sampling edge.
- Random handshakes with random dir (WIDTH=5) -> scoreboard confirms the count_gray/count_bin relation every cycle, a single-bit Gray change per update, and exactly one update per ack rising edge.
